// File: rtl/decoder_pkg.sv
// Shared types and constants for the 4-to-10 one-hot decode path.
package decoder_pkg;

  localparam int unsigned CODE_W    = 4;
  localparam int unsigned NUM_LINES = 10;
  localparam int unsigned MAX_CODE  = 9;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } dec_state_e;

endpackage

// File: rtl/onehot_lut_4to10.sv
// Combinational code-to-line lookup; codes above MAX_CODE give no line.
module onehot_lut_4to10
  import decoder_pkg::*;
(
  input  logic [CODE_W-1:0]    code_i,
  output logic [NUM_LINES-1:0] onehot_o,
  output logic                 code_ok_o
);

  always_comb begin
    onehot_o  = '0;
    code_ok_o = 1'b1;
    case (code_i)
      4'd0:    onehot_o = 10'b00_0000_0001;
      4'd1:    onehot_o = 10'b00_0000_0010;
      4'd2:    onehot_o = 10'b00_0000_0100;
      4'd3:    onehot_o = 10'b00_0000_1000;
      4'd4:    onehot_o = 10'b00_0001_0000;
      4'd5:    onehot_o = 10'b00_0010_0000;
      4'd6:    onehot_o = 10'b00_0100_0000;
      4'd7:    onehot_o = 10'b00_1000_0000;
      4'd8:    onehot_o = 10'b01_0000_0000;
      4'd9:    onehot_o = 10'b10_0000_0000;
      default: code_ok_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/decoder_4to10_hold.sv
// Registered 4-to-10 decoder: holds each line for HOLD_CYCLES,
// rejects codes 10-15 and counts them in a saturating counter.
module decoder_4to10_hold
  import decoder_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CODE_W-1:0]    in_code,
  output logic [NUM_LINES-1:0] out_onehot,
  output logic                 out_valid,
  output logic                 err,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  dec_state_e           state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [NUM_LINES-1:0] line_q, line_d;
  logic                 vld_q, vld_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] ecnt_q, ecnt_d;

  logic [NUM_LINES-1:0] lut_line;
  logic                 lut_ok;
  logic                 accept;
  logic [ERR_CNT_W-1:0] ecnt_base;

  onehot_lut_4to10 u_lut (
    .code_i    (in_code),
    .onehot_o  (lut_line),
    .code_ok_o (lut_ok)
  );

  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    vld_d   = vld_q;
    err_d   = accept && !lut_ok;
    unique case (state_q)
      IDLE: begin
        if (accept && lut_ok) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
          line_d  = lut_line;
          vld_d   = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          line_d  = '0;
          vld_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear takes effect before the increment of the same cycle.
  always_comb begin
    ecnt_base = err_clr ? '0 : ecnt_q;
    ecnt_d    = ecnt_base;
    if (accept && !lut_ok && ecnt_base != ERR_MAX)
      ecnt_d = ecnt_base + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign out_onehot = line_q;
  assign out_valid  = vld_q;
  assign err        = err_q;
  assign err_count  = ecnt_q;

endmodule

// File: tb/tb_decoder_4to10_hold.sv
// Directed bench: default instance (HOLD=4, W=8) and a small
// instance (HOLD=1, W=2) for saturation and single-cycle hold.
module tb_decoder_4to10_hold;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, a_ready, a_ovalid, a_err, a_clr;
  logic [3:0] a_code;
  logic [9:0] a_line;
  logic [7:0] a_cnt;
  logic       b_valid, b_ready, b_ovalid, b_err, b_clr;
  logic [3:0] b_code;
  logic [9:0] b_line;
  logic [1:0] b_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decoder_4to10_hold #(.HOLD_CYCLES(4), .ERR_CNT_W(8)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_valid), .in_ready(a_ready), .in_code(a_code),
    .out_onehot(a_line), .out_valid(a_ovalid),
    .err(a_err), .err_clr(a_clr), .err_count(a_cnt)
  );

  decoder_4to10_hold #(.HOLD_CYCLES(1), .ERR_CNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_valid), .in_ready(b_ready), .in_code(b_code),
    .out_onehot(b_line), .out_valid(b_ovalid),
    .err(b_err), .err_clr(b_clr), .err_count(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] exp_line;

  initial begin
    rst = 1'b1;
    a_valid = 0; a_code = 0; a_clr = 0;
    b_valid = 0; b_code = 0; b_clr = 0;
    step();
    step();
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_line", 32'(a_line), 32'd0);
    chk("rst_oval", 32'(a_ovalid), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_cnt", 32'(a_cnt), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_fall_ready", 32'(a_ready), 32'd1);

    // sweep codes 0..9
    for (int c = 0; c < 10; c++) begin
      exp_line = 10'd1 << c;
      a_valid = 1; a_code = 4'(c);
      step();
      a_valid = 0;
      for (int k = 0; k < 4; k++) begin
        if (k > 0) step();
        chk($sformatf("sw%0d_line%0d", c, k), 32'(a_line), 32'(exp_line));
        chk($sformatf("sw%0d_oval%0d", c, k), 32'(a_ovalid), 32'd1);
        chk($sformatf("sw%0d_rdy%0d", c, k), 32'(a_ready), 32'd0);
      end
      step();
      chk($sformatf("sw%0d_gap_line", c), 32'(a_line), 32'd0);
      chk($sformatf("sw%0d_gap_oval", c), 32'(a_ovalid), 32'd0);
      chk($sformatf("sw%0d_gap_rdy", c), 32'(a_ready), 32'd1);
    end

    // invalid codes: 12 once, 15 three times
    a_valid = 1; a_code = 4'd12;
    step();
    chk("inv12_err", 32'(a_err), 32'd1);
    chk("inv12_cnt", 32'(a_cnt), 32'd1);
    chk("inv12_rdy", 32'(a_ready), 32'd1);
    chk("inv12_line", 32'(a_line), 32'd0);
    a_code = 4'd15;
    for (int k = 2; k <= 4; k++) begin
      step();
      chk($sformatf("inv15_err%0d", k), 32'(a_err), 32'd1);
      chk($sformatf("inv15_cnt%0d", k), 32'(a_cnt), 32'(k));
      chk($sformatf("inv15_rdy%0d", k), 32'(a_ready), 32'd1);
      chk($sformatf("inv15_line%0d", k), 32'(a_line), 32'd0);
    end
    a_valid = 0;
    step();
    chk("inv_err_drop", 32'(a_err), 32'd0);
    chk("inv_cnt_keep", 32'(a_cnt), 32'd4);

    // held input: code 5 kept valid across two periods
    a_valid = 1; a_code = 4'd5;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 4; k++) begin
        step();
        chk($sformatf("held%0d_line%0d", p, k), 32'(a_line), 32'h020);
      end
      step();
      chk($sformatf("held%0d_gap", p), 32'(a_line), 32'd0);
    end
    a_valid = 0;

    // reset in cycle 2 of a hold for code 7
    step();
    a_valid = 1; a_code = 4'd7;
    step();
    a_valid = 0;
    chk("mid_line1", 32'(a_line), 32'h080);
    step();
    chk("mid_line2", 32'(a_line), 32'h080);
    rst = 1'b1;
    #1;
    chk("mid_rdy_rst", 32'(a_ready), 32'd0);
    step();
    chk("mid_line", 32'(a_line), 32'd0);
    chk("mid_oval", 32'(a_ovalid), 32'd0);
    chk("mid_cnt", 32'(a_cnt), 32'd0);
    chk("mid_rdy", 32'(a_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rdy_after", 32'(a_ready), 32'd1);
    a_valid = 1; a_code = 4'd3;
    step();
    a_valid = 0;
    chk("post_line", 32'(a_line), 32'h008);
    chk("post_oval", 32'(a_ovalid), 32'd1);
    repeat (4) step();
    chk("post_gap", 32'(a_line), 32'd0);

    // HOLD_CYCLES=1 instance
    b_valid = 1; b_code = 4'd2;
    step();
    b_valid = 0;
    chk("h1_line", 32'(b_line), 32'h004);
    chk("h1_oval", 32'(b_ovalid), 32'd1);
    chk("h1_rdy", 32'(b_ready), 32'd0);
    step();
    chk("h1_gap_line", 32'(b_line), 32'd0);
    chk("h1_gap_rdy", 32'(b_ready), 32'd1);

    // saturation at 3 with a 2-bit counter
    b_valid = 1; b_code = 4'd10;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("sat_cnt%0d", k), 32'(b_cnt), 32'(k > 3 ? 3 : k));
    end
    b_clr = 1; b_code = 4'd14;
    step();
    chk("clr_inv_cnt", 32'(b_cnt), 32'd1);
    chk("clr_inv_err", 32'(b_err), 32'd1);
    b_valid = 0;
    step();
    chk("clr_alone_cnt", 32'(b_cnt), 32'd0);
    chk("clr_alone_err", 32'(b_err), 32'd0);
    b_clr = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
